// File: rtl/scope_trace_buffer_if.sv
// scope_trace_buffer_if: sample stream, frame strobe and pixel scan/colour bus of the trace buffer.
interface scope_trace_buffer_if;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       frame_start;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] colour_R;
    logic [7:0] colour_G;
    logic [7:0] colour_B;
    modport master (output sample_valid, sample_data, frame_start, pixel_x, pixel_y,
                    input colour_R, colour_G, colour_B);
    modport slave  (input sample_valid, sample_data, frame_start, pixel_x, pixel_y,
                    output colour_R, colour_G, colour_B);
endinterface

// File: rtl/scope_trace_buffer.sv
// scope_trace_buffer: triggered sweep capture into a ping-pong line buffer, rendered as trace plus graticule.
module scope_trace_buffer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int TRACE_Y0     = 112,
    parameter int GRID_STEP    = 64,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    scope_trace_buffer_if.slave  bus,
    input  logic [7:0]           trig_level,
    input  logic                 trig_falling,
    input  logic                 auto_mode,
    output logic                 capturing,
    output logic                 display_valid
);
    localparam int GB = $clog2(GRID_STEP);
    localparam int TW = $clog2(AUTO_TIMEOUT);
    typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, DONE} state_t;
    state_t state, state_d;
    logic [7:0] mem0 [H_ACTIVE];
    logic [7:0] mem1 [H_ACTIVE];
    logic          disp_bank;
    logic [9:0]    wr_idx, wr_idx_d, wr_addr;
    logic [TW-1:0] tcount, tcount_d;
    logic [7:0]    prev_sample, prev_d;
    logic          prev_valid, prev_valid_d;
    logic          we, swap, hit;
    always_comb begin
        hit = (prev_valid && (trig_falling ? (prev_sample >= trig_level && bus.sample_data < trig_level)
                                           : (prev_sample < trig_level && bus.sample_data >= trig_level)))
              || (auto_mode && tcount == TW'(AUTO_TIMEOUT - 1));
        state_d      = state;
        wr_idx_d     = wr_idx;
        tcount_d     = tcount;
        prev_d       = prev_sample;
        prev_valid_d = prev_valid;
        we           = 1'b0;
        swap         = 1'b0;
        case (state)
            WAIT_TRIG: begin
                if (!auto_mode) tcount_d = '0;
                if (bus.sample_valid) begin
                    if (hit) begin
                        we       = 1'b1;
                        wr_idx_d = 10'd1;
                        state_d  = CAPTURE;
                    end else begin
                        prev_d       = bus.sample_data;
                        prev_valid_d = 1'b1;
                        tcount_d     = auto_mode ? tcount + TW'(1) : '0;
                    end
                end
            end
            CAPTURE: begin
                if (bus.sample_valid) begin
                    we       = 1'b1;
                    wr_idx_d = wr_idx + 10'd1;
                    if (wr_idx == 10'(H_ACTIVE - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.frame_start) begin
                    swap         = 1'b1;
                    prev_valid_d = 1'b0;
                    tcount_d     = '0;
                    wr_idx_d     = '0;
                    state_d      = WAIT_TRIG;
                end
            end
            default: state_d = WAIT_TRIG;
        endcase
        wr_addr = (state == CAPTURE) ? wr_idx : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= WAIT_TRIG;
            disp_bank     <= 1'b0;
            wr_idx        <= '0;
            tcount        <= '0;
            prev_sample   <= '0;
            prev_valid    <= 1'b0;
            capturing     <= 1'b0;
            display_valid <= 1'b0;
        end else begin
            state       <= state_d;
            wr_idx      <= wr_idx_d;
            tcount      <= tcount_d;
            prev_sample <= prev_d;
            prev_valid  <= prev_valid_d;
            capturing   <= (state_d == CAPTURE);
            if (swap) begin
                disp_bank     <= ~disp_bank;
                display_valid <= 1'b1;
            end
        end
    end
    // The write bank is always the one not on screen.
    always_ff @(posedge clock) begin
        if (we && !reset) begin
            if (disp_bank) mem0[wr_addr] <= bus.sample_data;
            else           mem1[wr_addr] <= bus.sample_data;
        end
    end
    logic [9:0] rd_addr, px_q, py_q, trace_y;
    logic [7:0] rd;
    logic       in_range, on_trace, on_grid;
    logic [23:0] rgb_d;
    assign rd_addr = (bus.pixel_x < 10'(H_ACTIVE)) ? bus.pixel_x : '0;
    always_ff @(posedge clock) begin
        rd   <= disp_bank ? mem1[rd_addr] : mem0[rd_addr];
        px_q <= bus.pixel_x;
        py_q <= bus.pixel_y;
    end
    always_comb begin
        trace_y  = 10'(TRACE_Y0) + {2'b00, ~rd};
        in_range = px_q < 10'(H_ACTIVE) && py_q < 10'(V_ACTIVE);
        on_trace = display_valid && py_q == trace_y;
        on_grid  = px_q[GB-1:0] == '0 || py_q[GB-1:0] == '0;
        rgb_d    = !in_range ? 24'h000000 : on_trace ? 24'hFFFF00 : on_grid ? 24'h404040 : 24'h000000;
    end
    always_ff @(posedge clock) begin
        if (reset) {bus.colour_R, bus.colour_G, bus.colour_B} <= '0;
        else       {bus.colour_R, bus.colour_G, bus.colour_B} <= rgb_d;
    end
endmodule

// File: tb/tb_scope_trace_buffer.sv
// tb_scope_trace_buffer: scoreboarded pixel checks plus trigger/FSM checks for scope_trace_buffer.
module tb_scope_trace_buffer;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] trig_level;
    logic       trig_falling, auto_mode;
    logic       capturing, display_valid;
    scope_trace_buffer_if bus();
    scope_trace_buffer dut (
        .clock(clock), .reset(reset), .bus(bus.slave), .trig_level(trig_level),
        .trig_falling(trig_falling), .auto_mode(auto_mode),
        .capturing(capturing), .display_valid(display_valid)
    );
    always #20 clock = ~clock;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;
    typedef struct {
        int          due;
        logic [23:0] exp;
        string       tag;
    } ent_t;
    ent_t sb[$];
    ent_t e_m;
    logic [7:0] shown [640];
    logic [7:0] pend [640];
    logic       dv_m = 1'b0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [23:0] expc(input int x, input int y);
        if (x >= 640 || y >= 480) return 24'h000000;
        if (dv_m && y == 112 + 255 - int'(shown[x])) return 24'hFFFF00;
        if (x % 64 == 0 || y % 64 == 0) return 24'h404040;
        return 24'h000000;
    endfunction
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e_m = sb.pop_front();
            check(e_m.tag, {8'h00, bus.colour_R, bus.colour_G, bus.colour_B}, {8'h00, e_m.exp});
        end
    end
    task automatic pix(input int x, input int y);
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        sb.push_back('{cyc + 2, expc(x, y), $sformatf("pix(%0d,%0d)", x, y)});
        @(negedge clock);
    endtask
    task automatic send(input logic [7:0] v);
        bus.sample_valid = 1'b1;
        bus.sample_data  = v;
        @(negedge clock);
        bus.sample_valid = 1'b0;
    endtask
    task automatic frame(input logic with_sample);
        bus.frame_start  = 1'b1;
        bus.sample_valid = with_sample;
        bus.sample_data  = 8'd255;
        @(negedge clock);
        bus.frame_start  = 1'b0;
        bus.sample_valid = 1'b0;
    endtask
    task automatic drain();
        repeat (4) @(negedge clock);
    endtask
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1; trig_level = 8'd128; trig_falling = 1'b0; auto_mode = 1'b0;
        bus.sample_valid = 1'b0; bus.sample_data = '0; bus.frame_start = 1'b0;
        bus.pixel_x = '0; bus.pixel_y = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_capturing", capturing, 0);
        check("rst_display_valid", display_valid, 0);
        check("rst_colour", {bus.colour_R, bus.colour_G, bus.colour_B}, 0);
        repeat (5) @(negedge clock);
        check("idle_capturing", capturing, 0);
        pix(0, 0); pix(10, 10);
        drain();
        // rising-edge sweep: trigger on 130, then a ramp
        send(8'd100); send(8'd120);
        check("rise_pre_trig", capturing, 0);
        send(8'd130);
        check("rise_trig", capturing, 1);
        pend[0] = 8'd130;
        for (int i = 1; i < 639; i++) begin send(8'(i)); pend[i] = 8'(i); end
        check("rise_cap_638", capturing, 1);
        send(8'(639)); pend[639] = 8'(639);
        check("rise_done", capturing, 0);
        repeat (3) send(8'd7);
        pix(0, 237);
        drain();
        check("rise_dv_before_swap", display_valid, 0);
        frame(1'b1);
        shown = pend; dv_m = 1'b1;
        check("rise_dv_after_swap", display_valid, 1);
        pix(0, 237); pix(0, 238); pix(5, 362); pix(5, 363); pix(255, 112);
        pix(300, 323); pix(639, 240); pix(640, 64); pix(64, 480); pix(128, 100);
        drain();
        // falling-edge sweep; a frame_start while waiting must not swap
        trig_falling = 1'b1; trig_level = 8'd50;
        repeat (20) send(8'd60);
        check("fall_const_no_trig", capturing, 0);
        frame(1'b0);
        check("fall_wait_frame_dv", display_valid, 1);
        pix(0, 237); pix(300, 323);
        drain();
        repeat (20) send(8'd60);
        check("fall_const_no_trig2", capturing, 0);
        send(8'd40);
        check("fall_trig", capturing, 1);
        pend[0] = 8'd40;
        for (int i = 1; i < 640; i++) begin send(8'd200); pend[i] = 8'd200; end
        check("fall_done", capturing, 0);
        frame(1'b1);
        shown = pend;
        check("fall_dv", display_valid, 1);
        pix(0, 327); pix(1, 167); pix(1, 237); pix(0, 237); pix(639, 167);
        drain();
        // auto trigger on constant input
        trig_falling = 1'b0; trig_level = 8'd128; auto_mode = 1'b0;
        repeat (5000) send(8'd10);
        check("auto_off_no_trig", capturing, 0);
        auto_mode = 1'b1;
        repeat (4095) send(8'd10);
        check("auto_4095", capturing, 0);
        send(8'd10);
        check("auto_4096", capturing, 1);
        repeat (299) send(8'd20);
        check("auto_wr300", capturing, 1);
        // reset mid-sweep: nothing partial may be shown
        reset = 1'b1;
        @(negedge clock);
        dv_m = 1'b0;
        check("abort_capturing", capturing, 0);
        check("abort_dv", display_valid, 0);
        reset = 1'b0; auto_mode = 1'b0;
        frame(1'b0);
        check("abort_frame_dv", display_valid, 0);
        pix(0, 237); pix(1, 167); pix(5, 362);
        drain();
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
